// File: rtl/lcd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl_if
// Description : Write/status bus between the LSU-side I/O decode and the
//               HD44780 LCD controller.
//               i_wr_en   - one-cycle write strobe (already qualified)
//               i_wr_rs   - 0 = command, 1 = data
//               i_wr_byte - byte to send
//               o_status  - status word polled by software
//               master: I/O decode side, slave: lcd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_ctrl_if;
  logic        i_wr_en;
  logic        i_wr_rs;
  logic [7:0]  i_wr_byte;
  logic [31:0] o_status;

  modport master (output i_wr_en, output i_wr_rs, output i_wr_byte, input  o_status);
  modport slave  (input  i_wr_en, input  i_wr_rs, input  i_wr_byte, output o_status);
endinterface
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl
// Description : Memory-mapped responder for an HD44780-style character LCD.
//               Buffers command/data byte writes in a small FIFO and replays
//               them as correctly timed LCD bus cycles:
//               SETUP (RS/DATA stable) -> PULSE (EN high) -> HOLD -> WAIT.
//               Optional macro LCD_INIT_SEQ_EN: when defined, a power-up wait
//               and the init sequence 38,38,0C,01,06 run after reset; when
//               undefined the block comes out of reset idle and ready.
// Ports       : i_clk      - clock
//               i_reset    - synchronous, active-low reset
//               bus        - lcd_ctrl_if.slave (write strobe/rs/byte, status)
//                            status: [0] busy, [1] fifo_full, [2] init_done,
//                            [3] overflow (sticky), [8:4] fifo_count
//               o_lcd_on   - LCD power/backlight enable
//               o_lcd_en   - LCD EN
//               o_lcd_rs   - LCD RS
//               o_lcd_rw   - LCD RW (write-only, tied 0)
//               o_lcd_data - LCD DB[7:0]
//               All T_* parameters must be >= 1.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_SU_CYC    = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000,
  parameter int T_PWRUP_CYC = 750000
) (
  input  wire         i_clk,
  input  wire         i_reset,
  lcd_ctrl_if.slave   bus,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

  // Timing counter sized for the longest interval
  localparam int c_TMAX_A = (T_SU_CYC  > T_EN_CYC)    ? T_SU_CYC  : T_EN_CYC;
  localparam int c_TMAX_B = (T_CMD_CYC > T_CLR_CYC)   ? T_CMD_CYC : T_CLR_CYC;
  localparam int c_TMAX_C = (c_TMAX_A  > T_PWRUP_CYC) ? c_TMAX_A  : T_PWRUP_CYC;
  localparam int c_TMAX   = (c_TMAX_B  > c_TMAX_C)    ? c_TMAX_B  : c_TMAX_C;
  localparam int c_TW     = $clog2(c_TMAX) + 1;

  // Counter load values: a state lasts (load + 1) cycles
  localparam logic [c_TW-1:0] c_LD_SU  = c_TW'(T_SU_CYC  - 1);
  localparam logic [c_TW-1:0] c_LD_EN  = c_TW'(T_EN_CYC  - 1);
  localparam logic [c_TW-1:0] c_LD_CMD = c_TW'(T_CMD_CYC - 1);
  localparam logic [c_TW-1:0] c_LD_CLR = c_TW'(T_CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_INIT  = 3'd1,
    S_IDLE  = 3'd2,
    S_SETUP = 3'd3,
    S_PULSE = 3'd4,
    S_HOLD  = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_TW-1:0]   r_cnt, w_cnt_nxt;

  logic [8:0]        r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wp, r_rp;
  logic [c_CW-1:0]   r_count;
  logic              r_overflow;
  logic              r_init_done;

  logic              r_lcd_on, r_lcd_en, r_lcd_rs;
  logic [7:0]        r_lcd_data;

  logic              w_full, w_push, w_pop, w_busy, w_slow;

`ifdef LCD_INIT_SEQ_EN
  localparam logic [c_TW-1:0] c_LD_PWRUP  = c_TW'(T_PWRUP_CYC - 1);
  localparam logic [2:0]      c_INIT_LEN  = 3'd5;

  logic [2:0] r_init_idx;
  logic       w_init_load, w_init_fin;

  function automatic logic [7:0] f_init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: f_init_byte = 8'h38;  // function set: 8-bit, 2 lines
      3'd2:       f_init_byte = 8'h0C;  // display on, cursor off
      3'd3:       f_init_byte = 8'h01;  // clear
      default:    f_init_byte = 8'h06;  // entry mode: increment
    endcase
  endfunction
`endif

  // Write is judged against the count before any same-cycle pop
  assign w_full = (r_count == c_DEPTH);
  assign w_push = bus.i_wr_en && !w_full;
  assign w_busy = !((r_state == S_IDLE) && (r_count == '0));
  // Clear and Home need the long execution wait
  assign w_slow = !r_lcd_rs && ((r_lcd_data == 8'h01) || (r_lcd_data == 8'h02) ||
                                (r_lcd_data == 8'h03));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    w_init_load = 1'b0;
    w_init_fin  = 1'b0;
`endif
    if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
    case (r_state)
`ifdef LCD_INIT_SEQ_EN
      S_PWRUP: begin
        if (r_cnt == '0) w_state_nxt = S_INIT;
      end
      S_INIT: begin
        w_init_load = 1'b1;
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = c_LD_SU;
      end
`endif
      S_IDLE: begin
        if (r_init_done && (r_count != '0)) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = c_LD_SU;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = c_LD_EN;
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_LD_SU;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_slow ? c_LD_CLR : c_LD_CMD;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
          if (r_init_idx != c_INIT_LEN) begin
            w_state_nxt = S_INIT;
          end else begin
            w_state_nxt = S_IDLE;
            w_init_fin  = !r_init_done;
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wp] <= {bus.i_wr_rs, bus.i_wr_byte};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
`ifdef LCD_INIT_SEQ_EN
      r_state     <= S_PWRUP;
      r_cnt       <= c_LD_PWRUP;
      r_init_done <= 1'b0;
      r_init_idx  <= 3'd0;
`else
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_init_done <= 1'b1;
`endif
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_lcd_on    <= 1'b1;
      r_lcd_en    <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.i_wr_en && w_full) r_overflow <= 1'b1;
      // RS/DATA change only on the pop or init-load cycle
      if (w_pop) begin
        {r_lcd_rs, r_lcd_data} <= r_mem[r_rp];
      end
`ifdef LCD_INIT_SEQ_EN
      if (w_init_load) begin
        r_lcd_rs   <= 1'b0;
        r_lcd_data <= f_init_byte(r_init_idx);
        r_init_idx <= r_init_idx + 1'b1;
      end
      if (w_init_fin) r_init_done <= 1'b1;
`endif
      // Registered from next state so EN is high exactly while in PULSE
      r_lcd_en <= (w_state_nxt == S_PULSE);
      r_lcd_on <= 1'b1;
    end
  end

  assign bus.o_status = {23'd0, 5'(r_count), r_overflow, r_init_done, w_full, w_busy};
  assign o_lcd_on     = r_lcd_on;
  assign o_lcd_en     = r_lcd_en;
  assign o_lcd_rs     = r_lcd_rs;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_data   = r_lcd_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_ctrl
// Description : Directed self-checking bench for lcd_ctrl. Works with and
//               without LCD_INIT_SEQ_EN; expected tables follow the build.
//               A negedge monitor records every EN pulse (data, rs, width,
//               setup stability, gap to previous pulse, init_done at rise).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl;

  localparam int T_SU  = 2;
  localparam int T_EN  = 12;
  localparam int T_CMD = 20;
  localparam int T_CLR = 50;

`ifdef LCD_INIT_SEQ_EN
  localparam int N1     = 9;
  localparam int N_INIT = 5;
  localparam logic [7:0] E_DATA  [N1] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06,
                                          8'h30, 8'h31, 8'h32, 8'h33};
  localparam logic       E_RS    [N1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                          1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic       E_IDONE [N1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                          1'b1, 1'b1, 1'b1, 1'b1};
  // en-low samples before each pulse: HOLD+WAIT+load+SETUP (55 after Clear)
  localparam int         E_GAP   [N1] = '{-1, 25, 25, 25, 55, 25, 25, 25, 25};
  localparam logic [31:0] C_RST_ST   = 32'h0000_0001;
  localparam logic [31:0] C_BURST_ST = 32'h0000_004B;
`else
  localparam int N1     = 5;
  localparam int N_INIT = 0;
  localparam logic [7:0] E_DATA  [N1] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
  localparam logic       E_RS    [N1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic       E_IDONE [N1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam int         E_GAP   [N1] = '{-1, 25, 25, 25, 25};
  localparam logic [31:0] C_RST_ST   = 32'h0000_0004;
  localparam logic [31:0] C_BURST_ST = 32'h0000_004F;
`endif

  logic       clk;
  logic       i_reset;
  logic       o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;

  lcd_ctrl_if u_bus ();

  lcd_ctrl #(
    .FIFO_DEPTH  (4),
    .T_SU_CYC    (T_SU),
    .T_EN_CYC    (T_EN),
    .T_CMD_CYC   (T_CMD),
    .T_CLR_CYC   (T_CLR),
    .T_PWRUP_CYC (10)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .bus        (u_bus),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_data (o_lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic       rw;
    logic       idone;
    int         len;
    int         pre;
    int         gap;
    int         chg;
  } pulse_t;

  pulse_t     q[$];
  pulse_t     m_cur;
  int         m_stab = 0;
  int         m_gap  = 0;
  logic [8:0] m_prev = 9'h0;
  logic       m_prev_en = 1'b0;

  always @(negedge clk) begin
    if (!i_reset) begin
      m_prev_en = 1'b0;
      m_stab    = 0;
      m_gap     = 0;
      m_prev    = {o_lcd_rs, o_lcd_data};
    end else begin
      if ({o_lcd_rs, o_lcd_data} != m_prev) m_stab = 0;
      else                                   m_stab++;
      if (o_lcd_en) begin
        if (!m_prev_en) begin
          m_cur.data  = o_lcd_data;
          m_cur.rs    = o_lcd_rs;
          m_cur.rw    = o_lcd_rw;
          m_cur.idone = u_bus.o_status[2];
          m_cur.pre   = m_stab;
          m_cur.gap   = m_gap;
          m_cur.len   = 0;
          m_cur.chg   = 0;
        end else if ({o_lcd_rs, o_lcd_data} != m_prev) begin
          m_cur.chg++;
        end
        m_cur.len++;
        m_gap = 0;
      end else begin
        if (m_prev_en) q.push_back(m_cur);
        m_gap++;
      end
      m_prev    = {o_lcd_rs, o_lcd_data};
      m_prev_en = o_lcd_en;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic rs, input logic [7:0] b);
    u_bus.i_wr_en   = 1'b1;
    u_bus.i_wr_rs   = rs;
    u_bus.i_wr_byte = b;
    tick();
    u_bus.i_wr_en   = 1'b0;
  endtask

  task automatic wait_en(input logic lvl, input int lim, input string tag);
    int n = 0;
    while (o_lcd_en !== lvl && n < lim) begin
      tick();
      n++;
    end
    if (o_lcd_en !== lvl) chk_eq(tag, 32'(o_lcd_en), 32'(lvl));
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int n = 0;
    while (u_bus.o_status[0] && n < lim) begin
      tick();
      n++;
    end
    chk_eq(tag, 32'(u_bus.o_status[0]), 32'd0);
  endtask

  task automatic chk_pulse(input logic [7:0] d, input logic rs, input int gap, input logic idone);
    pulse_t p;
    if (q.size() == 0) begin
      chk_eq("pulse_present", 32'd0, 32'd1);
    end else begin
      p = q.pop_front();
      chk_eq("pulse_data",  32'(p.data),  32'(d));
      chk_eq("pulse_rs",    32'(p.rs),    32'(rs));
      chk_eq("pulse_rw",    32'(p.rw),    32'd0);
      chk_eq("pulse_len",   32'(p.len),   32'(T_EN));
      chk_eq("pulse_setup", 32'(p.pre >= T_SU), 32'd1);
      chk_eq("pulse_stable", 32'(p.chg),  32'd0);
      chk_eq("pulse_idone", 32'(p.idone), 32'(idone));
      if (gap >= 0) chk_eq("pulse_gap", 32'(p.gap), 32'(gap));
    end
  endtask

  // Single write from idle: fifo_count, EN latency, hold, busy duration
  task automatic do_one(input logic rs, input logic [7:0] b, input int busy_exp);
    int lat, nb;
    wr(rs, b);
    chk_eq("one_count", 32'(u_bus.o_status[8:4]), 32'd1);
    lat = 1;
    while (!o_lcd_en && lat < 50) begin
      tick();
      lat++;
    end
    // write edge precedes the first sample, so cycles from write = lat-1
    chk_eq("one_latency", 32'(lat - 1), 32'(T_SU + 1));
    wait_en(1'b0, 50, "tmo_one_fall");
    nb = 0;
    while (u_bus.o_status[0] && nb < 500) begin
      if (nb < T_SU) chk_eq("one_hold", {23'd0, o_lcd_rs, o_lcd_data}, {23'd0, rs, b});
      nb++;
      tick();
    end
    chk_eq("one_busy", 32'(nb), 32'(busy_exp));
    chk_pulse(b, rs, -1, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n, n55;
    i_reset         = 1'b0;
    u_bus.i_wr_en   = 1'b0;
    u_bus.i_wr_rs   = 1'b0;
    u_bus.i_wr_byte = 8'h00;
    repeat (3) tick();

    chk_eq("rst_en",     32'(o_lcd_en),   32'd0);
    chk_eq("rst_rs",     32'(o_lcd_rs),   32'd0);
    chk_eq("rst_rw",     32'(o_lcd_rw),   32'd0);
    chk_eq("rst_data",   32'(o_lcd_data), 32'h00);
    chk_eq("rst_on",     32'(o_lcd_on),   32'd1);
    chk_eq("rst_status", u_bus.o_status,  C_RST_ST);

    // Burst of 6 writes right after reset release
    i_reset = 1'b1;
    for (int i = 0; i < 6; i++) wr(1'b1, 8'h30 + 8'(i));
    chk_eq("burst_status", u_bus.o_status, C_BURST_ST);

    n = 0;
    while (q.size() < N1 && n < 3000) begin
      tick();
      n++;
    end
    chk_eq("seq_count", 32'(q.size()), 32'(N1));
    wait_idle(200, "seq_idle");
    chk_eq("seq_status", u_bus.o_status, 32'h0000_000C);
    for (int i = 0; i < N1; i++) chk_pulse(E_DATA[i], E_RS[i], E_GAP[i], E_IDONE[i]);

    // Single data byte, then a Clear command (long execution wait)
    do_one(1'b1, 8'h41, T_SU + T_CMD);
    do_one(1'b0, 8'h01, T_SU + T_CLR);
    chk_eq("no_extra_pulses", 32'(q.size()), 32'd0);

    // Reset in the middle of a 0x55 pulse
    wr(1'b1, 8'h55);
    wait_en(1'b1, 20, "tmo_55_rise");
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    chk_eq("midrst_en",     32'(o_lcd_en),   32'd0);
    chk_eq("midrst_data",   32'(o_lcd_data), 32'h00);
    chk_eq("midrst_status", u_bus.o_status,  C_RST_ST);
    i_reset = 1'b1;
    q.delete();
    wait_idle(1500, "midrst_idle");
    repeat (40) tick();
    chk_eq("midrst_pulses", 32'(q.size()), 32'(N_INIT));
    n55 = 0;
    foreach (q[i]) if (q[i].data == 8'h55) n55++;
    chk_eq("midrst_no55", 32'(n55), 32'd0);
    for (int i = 0; i < N_INIT; i++) chk_pulse(E_DATA[i], 1'b0, E_GAP[i], 1'b0);

    // Full FIFO in IDLE with a write on the pop cycle
    wr(1'b1, 8'h60);
    wait_en(1'b1, 20, "tmo_60_rise");
    for (int k = 0; k < 4; k++) wr(1'b1, 8'h61 + 8'(k));
    chk_eq("full_status", u_bus.o_status, 32'h0000_0047);
    wait_en(1'b0, 20, "tmo_60_fall");
    // HOLD(2)+WAIT(20) after the fall sample lands on the IDLE/pop cycle
    repeat (T_SU + T_CMD) tick();
    chk_eq("pop_cycle_status", u_bus.o_status, 32'h0000_0047);
    wr(1'b1, 8'h65);
    chk_eq("pop_push_status", u_bus.o_status, 32'h0000_003D);
    wait_idle(1000, "pop_push_idle");
    chk_pulse(8'h60, 1'b1, -1, 1'b1);
    for (int k = 0; k < 4; k++) chk_pulse(8'h61 + 8'(k), 1'b1, 25, 1'b1);
    chk_eq("pop_push_count", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Memory-mapped responder for the HD44780-style character LCD (DE2 board).
- The LSU-side I/O logic issues byte writes (command or data) and polls a status word. This block buffers the writes and produces correctly timed LCD bus cycles: RS/RW/DATA setup, EN pulse, hold, execution wait.
- Sits between the I/O write decode and the LCD pins. It replaces a raw register-to-pin LCD connection.

Parameters:
- FIFO_DEPTH, 4: write buffer entries; power of two, 2..16.
- T_SU_CYC, 2: clocks RS/DATA stable before EN rises, and held after EN falls.
- T_EN_CYC, 12: clocks EN held high (≥240 ns at 50 MHz).
- T_CMD_CYC, 2000: execution wait after a normal command or data write (40 µs).
- T_CLR_CYC, 82000: execution wait after Clear (0x01) or Home (0x02/0x03) with RS=0 (1.64 ms).
- T_PWRUP_CYC, 750000: wait after reset before the first init command (15 ms).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-low reset
- i_wr_en  in  1  one-cycle write strobe; already qualified by the I/O decode and by valid/!kill/!bubble
- i_wr_rs  in  1  0 = command, 1 = data
- i_wr_byte  in  8  byte to send
- o_status  out  32  [0] busy, [1] fifo_full, [2] init_done, [3] overflow (sticky), [8:4] fifo_count, others 0
- o_lcd_on  out  1  LCD power/backlight enable
- o_lcd_en  out  1  LCD EN
- o_lcd_rs  out  1  LCD RS
- o_lcd_rw  out  1  LCD RW; always 0 (write-only)
- o_lcd_data  out  8  LCD DB[7:0]

Behaviour:
- Reset values:
  - o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00, o_lcd_on=1.
  - FIFO empty, overflow=0, init_done=0, busy=1, state PWRUP.
- Reset mid-transfer: on the first clock with i_reset low, all of the above apply. EN drops in that same cycle, and the pending entry is discarded.
- All LCD outputs are registered. No combinational path from i_wr_* to the pins.
- FIFO write:
  - A write is accepted on a cycle where i_wr_en=1 and count<FIFO_DEPTH, sampled before any same-cycle pop.
  - A write at count==FIFO_DEPTH is dropped and sets overflow. Overflow clears only on reset.
  - Writes are accepted in every state, including during init.
- FIFO pop: occurs in IDLE when init_done=1 and count>0. On the same clock the entry is latched into the RS/DATA output registers.
- Simultaneous push and pop: count unchanged, both take effect.
- FSM states:
  - PWRUP: count T_PWRUP_CYC cycles, then go to INIT.
  - INIT: feeds the internal sequence 0x38, 0x38, 0x0C, 0x01, 0x06 (all RS=0) through SETUP..WAIT one at a time. After the last WAIT, set init_done=1 and go to IDLE.
  - IDLE: busy = (count>0). If init_done and count>0, pop and go to SETUP.
  - SETUP: EN=0, RS/DATA driven. After T_SU_CYC cycles go to PULSE.
  - PULSE: EN=1 for exactly T_EN_CYC cycles, then go to HOLD.
  - HOLD: EN=0, RS/DATA unchanged for T_SU_CYC cycles, then go to WAIT.
  - WAIT: count T_CLR_CYC if RS=0 and byte ∈ {0x01,0x02,0x03}, otherwise T_CMD_CYC. Then return to IDLE, or to INIT if the sequence is unfinished.
- busy = 1 in every state except IDLE with an empty FIFO.
- Timing counter:
  - Width is clog2 of the largest T_* parameter plus 1. The counter reloads on every state entry; it does not free-run.
  - Back-to-back entries cost one IDLE cycle each (pop cycle).
- fifo_count field reports 0..FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.
- o_lcd_data and o_lcd_rs change only on the pop/init-load cycle. Never while EN=1.

Optional Feature:
- LCD_INIT_SEQ_EN
  - Defined: PWRUP and INIT states are present as described.
  - Undefined: reset enters IDLE directly with init_done=1 and busy=0. Software performs initialisation itself, and T_PWRUP_CYC is unused.

Test Plan:
1. Use T_PWRUP_CYC=10, T_CMD_CYC=20, T_CLR_CYC=50, LCD_INIT_SEQ_EN defined, and release reset.
   - Required: exactly 5 EN pulses with DATA=0x38, 0x38, 0x0C, 0x01, 0x06 and RS=0.
   - Required: each EN high for 12 cycles.
   - Required: the gap after 0x01 is ≥50 cycles.
   - Required: init_done rises after the last WAIT.
2. After init, write RS=1 byte 0x41 ('A').
   - Required: fifo_count=1 the next cycle.
   - Required: RS=1 and DATA=0x41 stable 2 cycles before EN rises and 2 cycles after EN falls.
   - Required: busy clears T_CMD_CYC cycles after HOLD ends.
3. Issue 6 consecutive writes (0x30..0x35, RS=1) with FIFO_DEPTH=4 during PWRUP.
   - Required: the first 4 are accepted and the last 2 dropped; overflow=1 and fifo_full=1.
   - Required: after init, pins emit 0x30..0x33 only, in order.
4. With count==FIFO_DEPTH in IDLE, pulse i_wr_en on the pop cycle.
   - Required: the write is dropped, overflow=1, count ends at FIFO_DEPTH-1.
5. Assert i_reset low for 1 cycle during PULSE of data 0x55.
   - Required: EN=0 and DATA=0x00 on the next cycle, FIFO empty, state restarts at PWRUP.
   - Required: 0x55 is never re-sent.
6. With LCD_INIT_SEQ_EN undefined, write command 0x01.
   - Required: the first EN pulse starts T_SU_CYC+1 cycles after the write, with DATA=0x01 and RS=0.
   - Required: busy held for ≥T_CLR_CYC.
